// File: rtl/inst_cache_tag_assoc.sv
// inst_cache_tag_assoc: set-associative instruction-cache tag array with tree pseudo-LRU and flush sweep
// Ports:
//   clock, reset                         rising-edge clock, synchronous active-high reset
//   flush / busy                         whole-array invalidate request / sweep in progress
//   lookup_en, lookup_index, lookup_tag  lookup request, answered one cycle later
//   resp_valid, hit, hit_way, victim_way registered lookup response
//   fill_en, fill_index, fill_way, fill_tag  tag write, marks the way valid
module inst_cache_tag_assoc #(
  parameter int WAYS = 2,
  parameter int SETS = 64,
  parameter int TAG_W = 20,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  output logic             busy,
  input  logic             lookup_en,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             resp_valid,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic [WAY_W-1:0] victim_way,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag
);
  localparam int P_W = WAYS - 1;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;
  logic [IDX_W-1:0] cnt;
  logic [TAG_W-1:0] tags [SETS][WAYS];
  logic [WAYS-1:0] valid [SETS];
  logic [P_W-1:0] plru [SETS];
  logic lookup_ok, hit_c, any_inv;
  logic [WAY_W-1:0] hw_c, inv_c, victim_c;
  // PLRU bits are widened to a 3-bit tree so one body serves both associativities
  function automatic logic [WAY_W-1:0] plru_victim(input logic [P_W-1:0] p);
    logic [2:0] e;
    e = 3'(p);
    return (WAYS == 2) ? WAY_W'(e[0]) : WAY_W'(e[0] ? {1'b1, e[2]} : {1'b0, e[1]});
  endfunction
  function automatic logic [P_W-1:0] plru_touch(input logic [P_W-1:0] p, input logic [WAY_W-1:0] w);
    logic [2:0] e;
    logic [1:0] v;
    e = 3'(p);
    v = 2'(w);
    if (WAYS == 2) e[0] = ~v[0];
    else begin
      e[0] = ~v[1];
      if (v[1]) e[2] = ~v[0];
      else e[1] = ~v[0];
    end
    return P_W'(e);
  endfunction
  assign busy = (state == SWEEP);
  assign lookup_ok = lookup_en && (state == IDLE);
  // descending scan so the lowest-numbered match / invalid way wins
  always_comb begin
    hit_c = 1'b0;
    hw_c = '0;
    any_inv = 1'b0;
    inv_c = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid[lookup_index][i] && tags[lookup_index][i] == lookup_tag) begin
        hit_c = 1'b1;
        hw_c = WAY_W'(i);
      end
      if (!valid[lookup_index][i]) begin
        any_inv = 1'b1;
        inv_c = WAY_W'(i);
      end
    end
    victim_c = any_inv ? inv_c : plru_victim(plru[lookup_index]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SWEEP;
      cnt <= '0;
      resp_valid <= 1'b0;
      hit <= 1'b0;
      hit_way <= '0;
      victim_way <= '0;
    end else begin
      resp_valid <= lookup_ok;
      hit <= lookup_ok && hit_c;
      hit_way <= lookup_ok ? hw_c : '0;
      victim_way <= lookup_ok ? victim_c : '0;
      if (state == SWEEP) begin
        valid[cnt] <= '0;
        plru[cnt] <= '0;
        cnt <= cnt + 1'b1;
        if (cnt == IDX_W'(SETS - 1)) state <= IDLE;
      end else begin
        if (flush) begin
          state <= SWEEP;
          cnt <= '0;
        end
        if (lookup_ok && hit_c) plru[lookup_index] <= plru_touch(plru[lookup_index], hw_c);
        // later assignment lets a same-set fill override the lookup's PLRU update
        if (fill_en) begin
          tags[fill_index][fill_way] <= fill_tag;
          valid[fill_index][fill_way] <= 1'b1;
          plru[fill_index] <= plru_touch(plru[fill_index], fill_way);
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_cache_tag_assoc.sv
// tb_inst_cache_tag_assoc: scoreboard bench running a 2-way and a 4-way instance in lockstep
module tb_inst_cache_tag_assoc;
  localparam int SETS = 64;
  typedef struct {bit rv; bit h; int hw; int vw;} resp_t;
  logic clock = 1'b0;
  logic reset, flush, lookup_en, fill_en;
  logic [5:0] lookup_index, fill_index;
  logic [19:0] lookup_tag, fill_tag;
  logic [1:0] fill_way;
  logic busy2, rv2, hit2, hw2, vw2;
  logic busy4, rv4, hit4;
  logic [1:0] hw4, vw4;
  int checks = 0, errors = 0;
  resp_t q2[$], q4[$];
  bit mv [2][SETS][4];
  logic [19:0] mt [2][SETS][4];
  bit [2:0] mp [2][SETS];
  bit m_sweep = 1'b0;
  int m_cnt = 0;
  always #5 clock = ~clock;
  inst_cache_tag_assoc #(.WAYS(2), .SETS(SETS), .TAG_W(20)) d2 (
    .clock(clock), .reset(reset), .flush(flush), .busy(busy2),
    .lookup_en(lookup_en), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .resp_valid(rv2), .hit(hit2), .hit_way(hw2), .victim_way(vw2),
    .fill_en(fill_en), .fill_index(fill_index), .fill_way(fill_way[0]), .fill_tag(fill_tag));
  inst_cache_tag_assoc #(.WAYS(4), .SETS(SETS), .TAG_W(20)) d4 (
    .clock(clock), .reset(reset), .flush(flush), .busy(busy4),
    .lookup_en(lookup_en), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .resp_valid(rv4), .hit(hit4), .hit_way(hw4), .victim_way(vw4),
    .fill_en(fill_en), .fill_index(fill_index), .fill_way(fill_way), .fill_tag(fill_tag));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit [2:0] touch(input int n, input bit [2:0] p, input int w);
    bit [2:0] r;
    r = p;
    if (n == 2) r[0] = (w == 0);
    else begin
      r[0] = (w < 2);
      if (w < 2) r[1] = (w == 0);
      else r[2] = (w == 2);
    end
    return r;
  endfunction
  function automatic int victim(input int n, input bit [2:0] p);
    if (n == 2) return int'(p[0]);
    if (p[0]) return p[2] ? 3 : 2;
    return p[1] ? 1 : 0;
  endfunction
  task automatic model();
    resp_t e;
    int n, w, li, fi;
    bit inv;
    li = int'(lookup_index);
    fi = int'(fill_index);
    for (int c = 0; c < 2; c++) begin
      n = c ? 4 : 2;
      e = '{0, 0, 0, 0};
      if (!reset && !m_sweep) begin
        if (lookup_en) begin
          e.rv = 1;
          inv = 0;
          for (int k = 0; k < n; k++) begin
            if (!e.h && mv[c][li][k] && mt[c][li][k] == lookup_tag) begin e.h = 1; e.hw = k; end
            if (!inv && !mv[c][li][k]) begin inv = 1; e.vw = k; end
          end
          if (!inv) e.vw = victim(n, mp[c][li]);
          if (e.h && !(fill_en && fi == li)) mp[c][li] = touch(n, mp[c][li], e.hw);
        end
        if (fill_en) begin
          w = c ? int'(fill_way) : int'(fill_way[0]);
          mt[c][fi][w] = fill_tag;
          mv[c][fi][w] = 1;
          mp[c][fi] = touch(n, mp[c][fi], w);
        end
      end else if (!reset) begin
        for (int k = 0; k < 4; k++) mv[c][m_cnt][k] = 0;
        mp[c][m_cnt] = 0;
      end
      if (c == 0) q2.push_back(e);
      else q4.push_back(e);
    end
    if (reset) begin m_sweep = 1; m_cnt = 0; end
    else if (m_sweep) begin
      m_cnt++;
      if (m_cnt == SETS) begin m_sweep = 0; m_cnt = 0; end
    end else if (flush) begin m_sweep = 1; m_cnt = 0; end
  endtask
  task automatic step();
    resp_t e;
    model();
    @(posedge clock);
    #1;
    if (q2.size() == 0 || q4.size() == 0) check("sb_empty", 0, 1);
    else begin
      e = q2.pop_front();
      check("rv2", rv2, e.rv); check("hit2", hit2, e.h); check("hw2", hw2, e.hw); check("vw2", vw2, e.vw);
      e = q4.pop_front();
      check("rv4", rv4, e.rv); check("hit4", hit4, e.h); check("hw4", hw4, e.hw); check("vw4", vw4, e.vw);
    end
    check("busy2", busy2, m_sweep);
    check("busy4", busy4, m_sweep);
  endtask
  task automatic drive(input bit le, input int li, input logic [19:0] lt,
                       input bit fe, input int fi, input int fw, input logic [19:0] ft);
    lookup_en = le; lookup_index = 6'(li); lookup_tag = lt;
    fill_en = fe; fill_index = 6'(fi); fill_way = 2'(fw); fill_tag = ft;
    step();
    lookup_en = 0; fill_en = 0;
  endtask
  task automatic expect_sweep(input string tag);
    int n;
    n = 0;
    while (busy4 === 1'b1 && n < 200) begin n++; step(); end
    check(tag, n, SETS);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1; flush = 0; lookup_en = 0; fill_en = 0;
    lookup_index = 0; lookup_tag = 0; fill_index = 0; fill_way = 0; fill_tag = 0;
    repeat (3) step();
    check("reset_hit4", hit4, 0);
    check("reset_rv4", rv4, 0);
    reset = 0;
    expect_sweep("reset_sweep_len");
    drive(1, 9, 20'h11111, 0, 0, 0, 0);
    check("empty_victim4", vw4, 0);
    drive(0, 0, 0, 1, 5, 1, 20'hABCDE);
    drive(1, 5, 20'hABCDE, 0, 0, 0, 0);
    check("fill_hit_way2", hw2, 1);
    drive(1, 5, 20'h12345, 0, 0, 0, 0);
    for (int w = 0; w < 4; w++) drive(0, 0, 0, 1, 3, w, 20'hC0000 + 20'(w));
    drive(1, 3, 20'hC0000, 0, 0, 0, 0);
    check("set3_hit_way0", hit4, 1);
    drive(1, 3, 20'hFFFFF, 0, 0, 0, 0);
    check("plru_victim4", vw4, 2);
    drive(1, 7, 20'h77777, 1, 7, 0, 20'h77777);
    check("same_cycle_miss", hit4, 0);
    drive(1, 7, 20'h77777, 0, 0, 0, 0);
    check("after_fill_hit", hit4, 1);
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), 20'hA0000 + 20'($urandom_range(0, 5)),
            $urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom_range(0, 3),
            20'hA0000 + 20'($urandom_range(0, 5)));
      flush = 0;
    end
    while (busy4 === 1'b1) step();
    drive(0, 0, 0, 1, 2, 3, 20'h22222);
    flush = 1;
    step();
    flush = 0;
    lookup_en = 1; lookup_index = 2; lookup_tag = 20'h22222;
    fill_en = 1; fill_index = 4; fill_way = 1; fill_tag = 20'h44444;
    expect_sweep("flush_sweep_len");
    fill_en = 0;
    step();
    check("post_flush_miss", hit4, 0);
    drive(1, 4, 20'h44444, 0, 0, 0, 0);
    flush = 1;
    step();
    flush = 0;
    repeat (30) step();
    reset = 1;
    step();
    reset = 0;
    expect_sweep("reset_mid_sweep_len");
    drive(1, 5, 20'hABCDE, 0, 0, 0, 0);
    check("post_reset_miss", hit2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
